// File: rtl/vector_memory_access.sv
// Vector load/store sequencer: one valid/ready request in, one response pulse out.
// Stores are reformatted per lane (round half up, saturate to 8 bits) before reaching memory.
module vector_memory_access #(
    parameter int unsigned MEM_SIZE      = 35000,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 114,
    parameter int unsigned LANES         = 6,
    parameter int unsigned LANE_WIDTH    = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reqValid,
    output logic                     reqReady,
    input  logic                     reqWrite,
    input  logic [ADDRESS_WIDTH-1:0] reqAddress,
    input  logic [DATA_WIDTH-1:0]    reqData,
    output logic                     respValid,
    output logic                     respError,
    output logic [DATA_WIDTH-1:0]    respData,
    output logic                     memWriteEnable,
    output logic [ADDRESS_WIDTH-1:0] memReadAddress,
    output logic [ADDRESS_WIDTH-1:0] memWriteAddress,
    output logic [DATA_WIDTH-1:0]    memInputData,
    input  logic [DATA_WIDTH-1:0]    memOutputData
);

    localparam int unsigned FRAC_W = 10;
    localparam int unsigned INT_W  = 8;
    localparam int unsigned SUM_W  = INT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    resp_q, resp_d;

    logic [DATA_WIDTH-1:0]    fmt_c;
    logic [SUM_W-1:0]         lane_sum_c;
    logic [INT_W-1:0]         lane_val_c;
    logic                     oor_c;
    logic                     unused_req_bits_c;

    // Fraction bits below the rounding bit never influence the stored value.
    assign unused_req_bits_c = ^reqData;

    assign oor_c = (reqAddress >= ADDRESS_WIDTH'(MEM_SIZE));

    // Per-lane store format: negative -> 0, else integer + fraction msb, saturated at 255.
    always_comb begin
        fmt_c      = '0;
        lane_sum_c = '0;
        lane_val_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_sum_c = SUM_W'(reqData[i*LANE_WIDTH + FRAC_W +: INT_W])
                       + SUM_W'(reqData[i*LANE_WIDTH + FRAC_W - 1]);
            if (reqData[i*LANE_WIDTH + LANE_WIDTH - 1]) begin
                lane_val_c = '0;
            end else if (lane_sum_c > SUM_W'(255)) begin
                lane_val_c = '1;
            end else begin
                lane_val_c = lane_sum_c[INT_W-1:0];
            end
            fmt_c[i*LANE_WIDTH + FRAC_W +: INT_W] = lane_val_c;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    addr_d = reqAddress;
                    data_d = fmt_c;
                    if (oor_c) begin
                        err_d   = 1'b1;
                        resp_d  = '0;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        resp_d  = reqWrite ? fmt_c : '0;
                        state_d = reqWrite ? WRITE : READ;
                    end
                end
            end
            READ: begin
                resp_d  = memOutputData;
                state_d = RESP;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            resp_q  <= resp_d;
        end
    end

    // Memory-side and handshake outputs decode only from registered state.
    assign reqReady        = (state_q == IDLE);
    assign respValid       = (state_q == RESP);
    assign respError       = err_q;
    assign respData        = resp_q;
    assign memWriteEnable  = (state_q == WRITE);
    assign memWriteAddress = (state_q == WRITE) ? addr_q : '0;
    assign memReadAddress  = (state_q == READ)  ? addr_q : '0;
    assign memInputData    = (state_q == WRITE) ? data_q : '0;

endmodule

// File: tb/tb_vector_memory_access.sv
// Scoreboard bench for vector_memory_access with a behavioural combinational-read memory.
module tb_vector_memory_access;

    localparam int unsigned MEM_SIZE = 35000;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 114;
    localparam int unsigned LW = 19;
    localparam int unsigned NL = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqValid;
    logic          reqReady;
    logic          reqWrite;
    logic [AW-1:0] reqAddress;
    logic [DW-1:0] reqData;
    logic          respValid;
    logic          respError;
    logic [DW-1:0] respData;
    logic          memWriteEnable;
    logic [AW-1:0] memReadAddress;
    logic [AW-1:0] memWriteAddress;
    logic [DW-1:0] memInputData;
    logic [DW-1:0] memOutputData;

    typedef struct { int cyc; logic err; logic [DW-1:0] data; } rsp_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int hs; int lat; logic err; logic [DW-1:0] data; } exp_t;

    rsp_t          rsp_q[$];
    wr_t           wr_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] mem [0:MEM_SIZE-1];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vector_memory_access dut (
        .clk             (clk),
        .reset           (reset),
        .reqValid        (reqValid),
        .reqReady        (reqReady),
        .reqWrite        (reqWrite),
        .reqAddress      (reqAddress),
        .reqData         (reqData),
        .respValid       (respValid),
        .respError       (respError),
        .respData        (respData),
        .memWriteEnable  (memWriteEnable),
        .memReadAddress  (memReadAddress),
        .memWriteAddress (memWriteAddress),
        .memInputData    (memInputData),
        .memOutputData   (memOutputData)
    );

    assign memOutputData = (memReadAddress < MEM_SIZE) ? mem[memReadAddress[15:0]] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memWriteEnable && memWriteAddress < MEM_SIZE) mem[memWriteAddress[15:0]] <= memInputData;
    end

    always @(negedge clk) begin
        if (respValid) rsp_q.push_back('{cyc, respError, respData});
        if (memWriteEnable) wr_q.push_back('{cyc, memWriteAddress, memInputData});
    end

    // Reference format: (value + half LSB) / 1 integer step, clamp, negatives to zero.
    function automatic logic [DW-1:0] fmt_vec(input logic [DW-1:0] v);
        logic [DW-1:0] o;
        o = '0;
        for (int i = 0; i < int'(NL); i++) begin
            logic [LW-1:0] ln;
            int q;
            ln = v[i*LW +: LW];
            if (ln[LW-1]) q = 0;
            else begin
                q = (int'(ln[17:0]) + 512) / 1024;
                if (q > 255) q = 255;
            end
            o[i*LW + 10 +: 8] = 8'(q);
        end
        return o;
    endfunction

    function automatic logic [DW-1:0] lanes(input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                                            input logic [LW-1:0] l2, input logic [LW-1:0] l3,
                                            input logic [LW-1:0] l4, input logic [LW-1:0] l5);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Drives one request, waits for acceptance and pushes the expected response.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit keep, input bit track);
        int k;
        exp_t e;
        reqValid = 1'b1; reqWrite = w; reqAddress = a; reqData = d;
        k = 0;
        do begin @(negedge clk); k++; end while (!reqReady && k < 10);
        if (!reqReady) begin
            n_cmp++; n_bad++;
            $display("FAIL handshake: reqReady=0 after %0d cycles, required 1 (addr=%0d)", k, a);
        end else begin
            e.hs  = cyc;
            e.err = (a >= MEM_SIZE);
            e.lat = e.err ? 1 : 2;
            if (e.err) e.data = '0;
            else if (w) e.data = fmt_vec(d);
            else e.data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
            if (w && !e.err) ref_mem[int'(a)] = fmt_vec(d);
            if (track) exp_q.push_back(e);
        end
        @(posedge clk); #1;
        if (!keep) reqValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddress = '0; reqData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({reqReady, respValid, respError, memWriteEnable} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctrl: rdy/vld/err/we=%b required 1000",
                     {reqReady, respValid, respError, memWriteEnable});
        end
        n_cmp++;
        if (respData !== '0 || memReadAddress !== '0 || memWriteAddress !== '0 || memInputData !== '0) begin
            n_bad++;
            $display("FAIL reset_data: respData=%h rdAddr=%h wrAddr=%h inData=%h required all 0",
                     respData, memReadAddress, memWriteAddress, memInputData);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_q.delete(); wr_q.delete();
    endtask

    task automatic test_store_load();
        exp_t e;
        rsp_t r;
        logic [DW-1:0] v;
        logic [AW-1:0] a;
        wr_q.delete();
        v = lanes(19'(10 << 10), 19'(10 << 10), 19'(10 << 10), 19'(10 << 10), 19'(10 << 10), 19'(10 << 10));
        send(1'b1, 32'd5, v, 1'b0, 1'b1);
        repeat (4) @(posedge clk); #1;
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0].addr !== 32'd5 || wr_q[0].data !== exp_q[0].data ||
            wr_q[0].cyc != exp_q[0].hs + 1) begin
            n_bad++;
            $display("FAIL store_we: %0d write pulses (addr=%0d), required 1 pulse at addr 5 one cycle after accept",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : 32'hFFFF_FFFF);
        end
        send(1'b0, 32'd5, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = AW'($urandom_range(100, MEM_SIZE - 2));
            v = rand_vec();
            send(1'b1, a, v, 1'b0, 1'b1);
            send(1'b0, a, '0, 1'b0, 1'b1);
        end
        repeat (4) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rsp_q.size() == 0) begin
                n_bad++; $display("FAIL store_load: no response, required err=%0b data=%h", e.err, e.data);
            end else begin
                r = rsp_q.pop_front();
                if (r.err !== e.err || r.data !== e.data || r.cyc - e.hs != e.lat) begin
                    n_bad++;
                    $display("FAIL store_load: err=%0b data=%h lat=%0d, required err=%0b data=%h lat=%0d",
                             r.err, r.data, r.cyc - e.hs, e.err, e.data, e.lat);
                end
            end
        end
        n_cmp++;
        if (rsp_q.size() != 0) begin
            n_bad++; $display("FAIL store_load_extra: %0d extra responses, required 0", rsp_q.size());
            rsp_q.delete();
        end
    endtask

    task automatic test_format();
        exp_t e;
        rsp_t r;
        logic [DW-1:0] v;
        v = lanes({1'b0, 8'd255, 10'h200}, {1'b0, 8'd7, 10'h200}, {1'b1, 8'd50, 10'h000},
                  {1'b0, 8'd0, 10'h1FF}, {1'b0, 8'd254, 10'h3FF}, {1'b0, 8'd100, 10'h1FF});
        send(1'b1, 32'd6, v, 1'b0, 1'b1);
        send(1'b0, 32'd6, '0, 1'b0, 1'b1);
        send(1'b1, 32'(MEM_SIZE - 1), rand_vec(), 1'b0, 1'b1);
        send(1'b0, 32'(MEM_SIZE - 1), '0, 1'b0, 1'b1);
        repeat (4) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rsp_q.size() == 0) begin
                n_bad++; $display("FAIL format: no response, required err=%0b data=%h", e.err, e.data);
            end else begin
                r = rsp_q.pop_front();
                if (r.err !== e.err || r.data !== e.data || r.cyc - e.hs != e.lat) begin
                    n_bad++;
                    $display("FAIL format: err=%0b data=%h lat=%0d, required err=%0b data=%h lat=%0d",
                             r.err, r.data, r.cyc - e.hs, e.err, e.data, e.lat);
                end
            end
        end
        n_cmp++;
        if (rsp_q.size() != 0) begin
            n_bad++; $display("FAIL format_extra: %0d extra responses, required 0", rsp_q.size());
            rsp_q.delete();
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        rsp_t r;
        int hs0;
        wr_q.delete();
        send(1'b0, 32'(MEM_SIZE), '0, 1'b1, 1'b1);
        send(1'b1, 32'(MEM_SIZE), rand_vec(), 1'b1, 1'b1);
        send(1'b0, 32'hFFFF_FFFF, '0, 1'b0, 1'b1);
        repeat (4) @(posedge clk); #1;
        n_cmp++;
        if (wr_q.size() != 0) begin
            n_bad++; $display("FAIL oor_we: %0d write pulses, required 0", wr_q.size());
        end
        hs0 = exp_q[0].hs;
        for (int i = 1; i < exp_q.size(); i++) begin
            n_cmp++;
            if (exp_q[i].hs - exp_q[i-1].hs != 2) begin
                n_bad++; $display("FAIL oor_spacing: accept gap %0d cycles, required 2",
                                  exp_q[i].hs - exp_q[i-1].hs);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rsp_q.size() == 0) begin
                n_bad++; $display("FAIL oor: no response, required err=%0b data=%h", e.err, e.data);
            end else begin
                r = rsp_q.pop_front();
                if (r.err !== e.err || r.data !== e.data || r.cyc - e.hs != e.lat) begin
                    n_bad++;
                    $display("FAIL oor: err=%0b data=%h lat=%0d (first accept %0d), required err=%0b data=%h lat=%0d",
                             r.err, r.data, r.cyc - e.hs, hs0, e.err, e.data, e.lat);
                end
            end
        end
        n_cmp++;
        if (rsp_q.size() != 0) begin
            n_bad++; $display("FAIL oor_extra: %0d extra responses, required 0", rsp_q.size());
            rsp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        rsp_t r;
        for (int i = 0; i < 4; i++) send(1'b1, 32'(20 + i), rand_vec(), 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;
        rsp_q.delete();
        for (int i = 0; i < 4; i++) send(1'b0, 32'(20 + i), '0, (i < 3), 1'b1);
        repeat (4) @(posedge clk); #1;
        for (int i = 1; i < exp_q.size(); i++) begin
            n_cmp++;
            if (exp_q[i].hs - exp_q[i-1].hs != 3) begin
                n_bad++; $display("FAIL b2b_spacing: accept gap %0d cycles, required 3",
                                  exp_q[i].hs - exp_q[i-1].hs);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rsp_q.size() == 0) begin
                n_bad++; $display("FAIL b2b: no response, required data=%h", e.data);
            end else begin
                r = rsp_q.pop_front();
                if (r.err !== e.err || r.data !== e.data || r.cyc - e.hs != e.lat) begin
                    n_bad++;
                    $display("FAIL b2b: err=%0b data=%h lat=%0d, required err=%0b data=%h lat=%0d",
                             r.err, r.data, r.cyc - e.hs, e.err, e.data, e.lat);
                end
            end
        end
        n_cmp++;
        if (rsp_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_extra: %0d extra responses, required 0", rsp_q.size());
            rsp_q.delete();
        end
    endtask

    task automatic test_reset_write();
        exp_t e;
        rsp_t r;
        wr_q.delete(); rsp_q.delete();
        send(1'b1, 32'd9, rand_vec(), 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        n_cmp++;
        if (rsp_q.size() != 0) begin
            n_bad++; $display("FAIL rst_write_resp: %0d responses after reset, required 0", rsp_q.size());
            rsp_q.delete();
        end
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0].addr !== 32'd9) begin
            n_bad++; $display("FAIL rst_write_we: %0d write pulses, required 1 at addr 9", wr_q.size());
        end
        send(1'b0, 32'd9, '0, 1'b0, 1'b1);
        repeat (3) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rsp_q.size() == 0) begin
                n_bad++; $display("FAIL rst_write_load: no response, required data=%h", e.data);
            end else begin
                r = rsp_q.pop_front();
                if (r.err !== e.err || r.data !== e.data || r.cyc - e.hs != e.lat) begin
                    n_bad++;
                    $display("FAIL rst_write_load: err=%0b data=%h lat=%0d, required err=%0b data=%h lat=%0d",
                             r.err, r.data, r.cyc - e.hs, e.err, e.data, e.lat);
                end
            end
        end
    endtask

    task automatic test_reset_read();
        rsp_q.delete();
        send(1'b0, 32'd5, '0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (reqReady !== 1'b1 || respValid !== 1'b0) begin
            n_bad++; $display("FAIL rst_read_idle: reqReady=%b respValid=%b, required 1 0", reqReady, respValid);
        end
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (rsp_q.size() != 0) begin
            n_bad++; $display("FAIL rst_read_resp: %0d responses after reset, required 0", rsp_q.size());
            rsp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_format();
        test_out_of_range();
        test_back_to_back();
        test_reset_write();
        test_reset_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
